bft_port_arbiter: RTL and testbench
===================================

BFT_PORT_ARBITER -- requirements
Module: bft_port_arbiter

Interface
REQ-001: Parameter num_leaves, default 128, number of leaf ports in the BFT; sets the address width AW = clog2(num_leaves).
REQ-002: Parameter level, default 0, tree level of the owning switch; informational only, no functional effect in this block.
REQ-003: Parameter P_W, default 49, packet width in bits, including the valid bit.
REQ-004: Parameter OUT_DIR, default 2'b11, direction code served by this output port: 01 LEFT, 10 RIGHT, 11 UP; 00 VOID is illegal.
REQ-005: Parameter STALL_MAX, default 255, backpressure cycle limit before the stall flag is raised.
REQ-006: clk  input  1  single clock; all state updates on its rising edge.
REQ-007: reset  input  1  synchronous, active-high reset.
REQ-008: in_valid  input  3  per-input packet present; bit 0 LEFT input, bit 1 RIGHT input, bit 2 UP input.
REQ-009: in_dir  input  6  2-bit direction code per input, input i in bits [2i+1:2i], produced by the upstream direction logic.
REQ-010: in_data  input  3*P_W  packet per input, input i in bits [(i+1)*P_W-1 : i*P_W].
REQ-011: in_ready  output  3  one-hot pop strobe; input i's packet is consumed in that cycle.
REQ-012: out_valid  output  1  registered packet present on the output port.
REQ-013: out_data  output  P_W  registered packet.
REQ-014: out_src  output  2  index of the input that supplied out_data.
REQ-015: out_ready  input  1  downstream accepts the packet when out_valid && out_ready.
REQ-016: stall  output  1  sticky flag: backpressure exceeded STALL_MAX.
REQ-017: pkt_cnt  output  16  saturating count of packets delivered downstream.

Function
REQ-018: Request: req[i] = in_valid[i] && in_dir[i] == OUT_DIR; VOID-coded or foreign-direction packets are never requested or popped.
REQ-019: State: states IDLE (out_valid=0) and HOLD (out_valid=1); IDLE->HOLD on load; HOLD->IDLE on accept with no load; HOLD->HOLD on accept with load, or with no accept.
REQ-020: Load condition: load = (!out_valid || out_ready) && |req; back-to-back transfers, one packet per cycle, are supported.
REQ-021: Winner: round-robin from pointer ptr in {0,1,2}; first requesting index in order ptr, ptr+1, ptr+2 (mod 3).
REQ-022: On load: out_data <= in_data[winner], out_src <= winner, out_valid <= 1, ptr <= (winner+1) mod 3, all next edge.
REQ-023: in_ready[winner] = 1, combinational, in the load cycle only; in_ready = 000 otherwise; never more than one bit set.
REQ-024: Latency: a request seen at edge N appears on out_valid/out_data after edge N (one cycle).
REQ-025: Hold: while out_valid && !out_ready, out_data, out_src and ptr hold; no pop occurs.
REQ-026: Accept without load: out_valid <= 0; out_data and out_src hold their last values.
REQ-027: pkt_cnt increments by 1 on each out_valid && out_ready edge; it saturates at 16'hFFFF.
REQ-028: Stall counter: stall_cnt increments each cycle out_valid && !out_ready and clears on accept or when out_valid=0; stall <= 1 when stall_cnt reaches STALL_MAX; stall is cleared only by reset.
REQ-029: A single requester is granted every cycle it requests, provided the output is free.
REQ-030: Requests may drop without being granted; the arbiter keeps no request memory.

Reset
REQ-031: While reset=1 at an edge: out_valid=0, out_data=0, out_src=0, ptr=0, stall_cnt=0, stall=0, pkt_cnt=0; in_ready=000 combinationally during reset.
REQ-032: Reset during HOLD discards the held packet with no accept and no count; arbitration resumes the cycle after reset deasserts.

Verification
REQ-033: Reset, then inputs 0,1,2 all valid with dir=OUT_DIR and out_ready=1 -> grant order 0,1,2,0, in_ready one-hot each cycle, pkt_cnt=4 after four accepts.
REQ-034: Input 1 valid with dir=01 (not OUT_DIR=11), input 2 valid with dir=11 -> only input 2 granted; in_ready[1] never 1.
REQ-035: Load a packet, hold out_ready=0 for 10 cycles -> out_data stable, in_ready=000, ptr unchanged; raise out_ready -> accept, next winner per ptr.
REQ-036: STALL_MAX=4, out_ready=0 with out_valid=1 -> stall=1 after 4 stalled cycles; stays 1 after out_ready rises; cleared only by reset.
REQ-037: Assert reset mid-HOLD -> out_valid=0, pkt_cnt=0, ptr=0 at the next edge; the held packet is not counted.
REQ-038: Preload pkt_cnt near 16'hFFFF, stream continuously -> pkt_cnt holds at 16'hFFFF with no wrap.

Source files
------------

// File: rtl/bft_port_arbiter.sv
// BFT switch output-port arbiter: round-robin over LEFT/RIGHT/UP inputs
// into a one-deep registered output with stall and delivery counters.
module bft_port_arbiter #(
    parameter int         num_leaves = 128,
    parameter int         level      = 0,
    parameter int         P_W        = 49,
    parameter logic [1:0] OUT_DIR    = 2'b11,
    parameter int         STALL_MAX  = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       in_valid,
    input  logic [5:0]       in_dir,
    input  logic [3*P_W-1:0] in_data,
    output logic [2:0]       in_ready,
    output logic             out_valid,
    output logic [P_W-1:0]   out_data,
    output logic [1:0]       out_src,
    input  logic             out_ready,
    output logic             stall,
    output logic [15:0]      pkt_cnt
);

    localparam int AW = $clog2(num_leaves);
    localparam int SW = $clog2(STALL_MAX + 1);
    localparam logic [SW-1:0] S_MAX  = SW'(STALL_MAX);
    localparam logic [SW-1:0] S_LAST = SW'(STALL_MAX - 1);

    // VOID can never be served and a tree needs at least two leaves
    if (OUT_DIR == 2'b00 || AW < 1 || level < 0) begin : g_bad_cfg
        $error("bft_port_arbiter: illegal configuration");
    end

    typedef enum logic {IDLE, HOLD} state_t;

    state_t        state;
    logic [1:0]    ptr;
    logic [SW-1:0] stall_cnt;
    logic [2:0]    req;
    logic [1:0]    winner;
    logic          load;
    logic          accept;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            req[i] = in_valid[i] && (in_dir[2*i +: 2] == OUT_DIR);
        end
    end

    always_comb begin
        winner = 2'd0;
        case (ptr)
            2'd1:    winner = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd2:    winner = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: winner = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

    assign out_valid = (state == HOLD);
    assign accept    = out_valid && out_ready;
    assign load      = !reset && (!out_valid || out_ready) && (|req);
    assign in_ready  = load ? (3'b001 << winner) : 3'b000;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_data  <= '0;
            out_src   <= 2'd0;
            ptr       <= 2'd0;
            stall_cnt <= '0;
            stall     <= 1'b0;
            pkt_cnt   <= 16'd0;
        end else begin
            if (load) begin
                state    <= HOLD;
                out_data <= in_data[32'(winner)*P_W +: P_W];
                out_src  <= winner;
                ptr      <= (winner == 2'd2) ? 2'd0 : winner + 2'd1;
            end else if (accept) begin
                state <= IDLE;
            end

            if (accept && pkt_cnt != 16'hFFFF) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end

            if (out_valid && !out_ready) begin
                if (stall_cnt != S_MAX) begin
                    stall_cnt <= stall_cnt + 1'b1;
                end
                if (stall_cnt == S_LAST) begin
                    stall <= 1'b1;
                end
            end else begin
                stall_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bft_port_arbiter.sv
// Self-checking bench for bft_port_arbiter: vector table plus
// hand-written hold/stall, reset-in-hold and counter saturation sequences.
module tb_bft_port_arbiter;

    localparam int P_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       in_valid;
    logic [5:0]       in_dir;
    logic [3*P_W-1:0] in_data;
    logic [2:0]       in_ready;
    logic             out_valid;
    logic [P_W-1:0]   out_data;
    logic [1:0]       out_src;
    logic             out_ready;
    logic             stall;
    logic [15:0]      pkt_cnt;

    int checks   = 0;
    int failures = 0;

    bft_port_arbiter #(
        .num_leaves(128),
        .level(0),
        .P_W(P_W),
        .OUT_DIR(2'b11),
        .STALL_MAX(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_dir(in_dir),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_src(out_src),
        .out_ready(out_ready),
        .stall(stall),
        .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  v;
        logic [5:0]  d;
        logic        r;
        logic [2:0]  ir;
        logic        ov;
        logic [1:0]  src;
        logic [15:0] data;
        logic [15:0] cnt;
    } vec_t;

    vec_t tv[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 3'b000;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Per-input payloads: input 0 = 1111, 1 = 2222, 2 = 3333
        in_data   = {16'h3333, 16'h2222, 16'h1111};
        in_dir    = 6'b111111;
        in_valid  = 3'b000;
        out_ready = 1'b0;
        reset     = 1'b1;

        tv[0]  = '{3'b111, 6'b111111, 1'b1, 3'b001, 1'b1, 2'd0, 16'h1111, 16'd0};
        tv[1]  = '{3'b111, 6'b111111, 1'b1, 3'b010, 1'b1, 2'd1, 16'h2222, 16'd1};
        tv[2]  = '{3'b111, 6'b111111, 1'b1, 3'b100, 1'b1, 2'd2, 16'h3333, 16'd2};
        tv[3]  = '{3'b111, 6'b111111, 1'b1, 3'b001, 1'b1, 2'd0, 16'h1111, 16'd3};
        tv[4]  = '{3'b000, 6'b111111, 1'b1, 3'b000, 1'b0, 2'd0, 16'h1111, 16'd4};
        tv[5]  = '{3'b110, 6'b110111, 1'b1, 3'b100, 1'b1, 2'd2, 16'h3333, 16'd4};
        tv[6]  = '{3'b110, 6'b110111, 1'b1, 3'b100, 1'b1, 2'd2, 16'h3333, 16'd5};
        tv[7]  = '{3'b000, 6'b111111, 1'b1, 3'b000, 1'b0, 2'd2, 16'h3333, 16'd6};
        tv[8]  = '{3'b111, 6'b000000, 1'b1, 3'b000, 1'b0, 2'd2, 16'h3333, 16'd6};
        tv[9]  = '{3'b011, 6'b110110, 1'b1, 3'b000, 1'b0, 2'd2, 16'h3333, 16'd6};
        tv[10] = '{3'b010, 6'b111111, 1'b1, 3'b010, 1'b1, 2'd1, 16'h2222, 16'd6};
        tv[11] = '{3'b010, 6'b111111, 1'b1, 3'b010, 1'b1, 2'd1, 16'h2222, 16'd7};
        tv[12] = '{3'b010, 6'b111111, 1'b1, 3'b010, 1'b1, 2'd1, 16'h2222, 16'd8};
        tv[13] = '{3'b001, 6'b111111, 1'b0, 3'b000, 1'b1, 2'd1, 16'h2222, 16'd8};
        tv[14] = '{3'b001, 6'b111111, 1'b1, 3'b001, 1'b1, 2'd0, 16'h1111, 16'd9};
        tv[15] = '{3'b000, 6'b111111, 1'b1, 3'b000, 1'b0, 2'd0, 16'h1111, 16'd10};

        // Reset state; in_ready must stay low under reset even with requests
        tick();
        in_valid  = 3'b111;
        out_ready = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_src", 32'(out_src), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_pkt_cnt", 32'(pkt_cnt), 32'h0);
        reset    = 1'b0;
        in_valid = 3'b000;

        for (int i = 0; i < 16; i++) begin
            in_valid  = tv[i].v;
            in_dir    = tv[i].d;
            out_ready = tv[i].r;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tv[i].ir));
            tick();
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tv[i].ov));
            chk($sformatf("v%0d_out_src", i), 32'(out_src), 32'(tv[i].src));
            chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(tv[i].data));
            chk($sformatf("v%0d_pkt_cnt", i), 32'(pkt_cnt), 32'(tv[i].cnt));
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'h0);
        end

        // Hold under backpressure, stall threshold, sticky stall
        do_reset();
        in_dir    = 6'b111111;
        in_valid  = 3'b111;
        out_ready = 1'b0;
        #1;
        chk("hold_load_in_ready", 32'(in_ready), 32'h1);
        tick();
        chk("hold_out_valid", 32'(out_valid), 32'h1);
        for (int k = 1; k <= 10; k++) begin
            chk($sformatf("hold%0d_in_ready", k), 32'(in_ready), 32'h0);
            tick();
            chk($sformatf("hold%0d_out_data", k), 32'(out_data), 32'h1111);
            chk($sformatf("hold%0d_out_src", k), 32'(out_src), 32'h0);
            chk($sformatf("hold%0d_stall", k), 32'(stall), 32'(k >= 4));
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'h2);
        tick();
        chk("release_out_src", 32'(out_src), 32'h1);
        chk("release_out_data", 32'(out_data), 32'h2222);
        chk("release_pkt_cnt", 32'(pkt_cnt), 32'h1);
        in_valid = 3'b000;
        tick();
        tick();
        chk("drain_out_valid", 32'(out_valid), 32'h0);
        chk("sticky_stall", 32'(stall), 32'h1);
        reset = 1'b1;
        tick();
        chk("stall_cleared", 32'(stall), 32'h0);
        reset = 1'b0;

        // Reset while holding discards the packet without counting it
        in_valid  = 3'b111;
        out_ready = 1'b0;
        tick();
        tick();
        chk("midhold_out_valid", 32'(out_valid), 32'h1);
        reset     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("midhold_rst_in_ready", 32'(in_ready), 32'h0);
        tick();
        chk("midhold_rst_out_valid", 32'(out_valid), 32'h0);
        chk("midhold_rst_pkt_cnt", 32'(pkt_cnt), 32'h0);
        chk("midhold_rst_out_data", 32'(out_data), 32'h0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'h1);
        tick();
        chk("post_rst_out_src", 32'(out_src), 32'h0);

        // Continuous stream to drive pkt_cnt into saturation
        do_reset();
        in_valid  = 3'b111;
        out_ready = 1'b1;
        for (int e = 1; e <= 65535; e++) begin
            tick();
        end
        chk("sat_fffe", 32'(pkt_cnt), 32'hFFFE);
        tick();
        chk("sat_ffff", 32'(pkt_cnt), 32'hFFFF);
        repeat (4) tick();
        chk("sat_hold", 32'(pkt_cnt), 32'hFFFF);
        chk("sat_out_valid", 32'(out_valid), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
